// File: rtl/fir_tdm_prog_if.sv
// fir_tdm_prog_if
// Handshake and coefficient bus of the time-multiplexed FIR band.
//   sample in  : in_valid / in_ready / fir_in
//   result out : out_valid / out_ready / fir_out / sat
//   coef write : coef_we / coef_addr / coef_data
// master = the side feeding samples and coefficients; slave = the filter.
interface fir_tdm_prog_if #(
  parameter int WIDTH = 10,
  parameter int TAPS  = 30
);
  localparam int AW = $clog2(TAPS);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] fir_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] fir_out;
  logic             sat;
  logic             coef_we;
  logic [AW-1:0]    coef_addr;
  logic [WIDTH-1:0] coef_data;

  modport master (
    output in_valid, fir_in, out_ready, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, fir_out, sat
  );

  modport slave (
    input  in_valid, fir_in, out_ready, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, fir_out, sat
  );
endinterface

// File: rtl/fir_tdm_prog.sv
// fir_tdm_prog
// Coefficient-programmable FIR filter, sign-magnitude samples/coefficients.
// One multiply-accumulate unit walks TAPS taps serially over a circular
// sample history, one tap per clock.
// Ports:
//   clk_slow : sole clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : fir_tdm_prog_if.slave (sample in, result out, coef write)
module fir_tdm_prog #(
  parameter int WIDTH = 10,
  parameter int TAPS  = 30
) (
  input  logic           clk_slow,
  input  logic           rst,
  fir_tdm_prog_if.slave  bus
);
  localparam int MW    = WIDTH - 1;          // magnitude bits
  localparam int PW    = 2 * MW;             // product magnitude bits
  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = PW + 1 + AW;

  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
  localparam logic [AW:0]   TAPS_W   = (AW + 1)'(TAPS);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] coef [TAPS];
  logic [WIDTH-1:0] hist [TAPS];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    tap;
  logic [AW-1:0]    rd_idx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nx;
  logic [PW-1:0]    prod_mag;
  logic             prod_neg;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_abs;
  logic [ACC_W-1:0] res_full;
  logic             res_sat;
  logic [MW-1:0]    res_mag;
  logic [WIDTH-1:0] res_word;
  logic [WIDTH-1:0] fir_out_q;
  logic             sat_q;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             accept;
  logic             coef_wr;
  logic             last_tap;

  // FSM state register
  always_ff @(posedge clk_slow or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nx    = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nx = MAC;
      end
      MAC: begin
        if (last_tap) state_nx = OUT;
      end
      OUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept   = in_ready_c && bus.in_valid;
  assign coef_wr  = (state == IDLE) && bus.coef_we && ({1'b0, bus.coef_addr} < TAPS_W);
  assign last_tap = (tap == LAST_TAP);

  // Newest sample sits at wr_ptr; tap k reads the sample k steps older.
  // The sum can exceed AW bits but the wrapped result is always < TAPS.
  assign rd_idx = (wr_ptr >= tap) ? (wr_ptr - tap) : (wr_ptr + AW'(TAPS) - tap);

  always_comb begin
    prod_mag = PW'(coef[tap][MW-1:0]) * PW'(hist[rd_idx][MW-1:0]);
    prod_neg = (coef[tap][MW] ^ hist[rd_idx][MW]) && (prod_mag != '0);
    prod_ext = prod_neg ? (~ACC_W'(prod_mag) + 1'b1) : ACC_W'(prod_mag);
    acc_nx   = acc + prod_ext;
  end

  // Result is formed from the accumulator including the final tap's term
  always_comb begin
    acc_abs  = acc_nx[ACC_W-1] ? (~acc_nx + 1'b1) : acc_nx;
    res_full = acc_abs >> MW;
    res_sat  = (res_full > ACC_W'({MW{1'b1}}));
    res_mag  = res_sat ? '1 : res_full[MW-1:0];
    res_word = {acc_nx[ACC_W-1] && (res_mag != '0), res_mag};
  end

  always_ff @(posedge clk_slow or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        coef[i] <= '0;
        hist[i] <= '0;
      end
      wr_ptr    <= '0;
      tap       <= '0;
      acc       <= '0;
      fir_out_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      if (coef_wr) coef[bus.coef_addr] <= bus.coef_data;
      if (accept) begin
        // negative zero is stored as positive zero
        hist[wr_ptr] <= {(bus.fir_in[MW-1:0] != '0) && bus.fir_in[MW], bus.fir_in[MW-1:0]};
        acc          <= '0;
        tap          <= '0;
      end
      if (state == MAC) begin
        acc <= acc_nx;
        tap <= tap + 1'b1;
        if (last_tap) begin
          fir_out_q <= res_word;
          sat_q     <= res_sat;
          wr_ptr    <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.fir_out   = fir_out_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_fir_tdm_prog.sv
// tb_fir_tdm_prog
// Directed bench for fir_tdm_prog: a TAPS=4 instance for the hand-computed
// vectors and a TAPS=30 instance checked against a behavioural model.
module tb_fir_tdm_prog;
  logic clk_slow = 1'b0;
  always #5 clk_slow = ~clk_slow;

  logic rst4, rst30;
  int   tests = 0;
  int   fails = 0;

  fir_tdm_prog_if #(.WIDTH(10), .TAPS(4))  b4 ();
  fir_tdm_prog_if #(.WIDTH(10), .TAPS(30)) b30 ();

  fir_tdm_prog #(.WIDTH(10), .TAPS(4))  dut4  (.clk_slow(clk_slow), .rst(rst4),  .bus(b4.slave));
  fir_tdm_prog #(.WIDTH(10), .TAPS(30)) dut30 (.clk_slow(clk_slow), .rst(rst30), .bus(b30.slave));

  // behavioural model state for the TAPS=30 instance
  logic [9:0] gcoef [30];
  logic [9:0] ghist [30];
  int         gptr;

  task automatic tick;
    @(posedge clk_slow);
    #1;
  endtask

  task automatic wr4(input int a, input logic [9:0] d);
    b4.coef_we = 1'b1; b4.coef_addr = 2'(a); b4.coef_data = d;
    tick;
    b4.coef_we = 1'b0;
  endtask

  task automatic wr30(input int a, input logic [9:0] d);
    b30.coef_we = 1'b1; b30.coef_addr = 5'(a); b30.coef_data = d;
    tick;
    b30.coef_we = 1'b0;
  endtask

  task automatic run4(input logic [9:0] s, output logic [9:0] y, output logic so, output int lat);
    int n;
    n = 0;
    b4.fir_in = s; b4.in_valid = 1'b1;
    while (!b4.in_ready && n < 50) begin tick; n++; end
    tick;
    b4.in_valid = 1'b0;
    lat = 0;
    while (!b4.out_valid && lat < 50) begin tick; lat++; end
    y = b4.fir_out; so = b4.sat;
    b4.out_ready = 1'b1;
    tick;
    b4.out_ready = 1'b0;
  endtask

  task automatic run30(input logic [9:0] s, input logic cw, input int ca, input logic [9:0] cd,
                       output logic [9:0] y, output logic so, output int lat);
    int n;
    n = 0;
    b30.fir_in = s; b30.in_valid = 1'b1;
    b30.coef_we = cw; b30.coef_addr = 5'(ca); b30.coef_data = cd;
    while (!b30.in_ready && n < 50) begin tick; n++; end
    tick;
    b30.in_valid = 1'b0; b30.coef_we = 1'b0;
    lat = 0;
    while (!b30.out_valid && lat < 100) begin tick; lat++; end
    y = b30.fir_out; so = b30.sat;
    b30.out_ready = 1'b1;
    tick;
    b30.out_ready = 1'b0;
  endtask

  function automatic int sm2i(input logic [9:0] v);
    int m;
    m = int'(v[8:0]);
    return v[9] ? -m : m;
  endfunction

  task automatic model30(input logic [9:0] s, output logic [9:0] y, output logic so);
    int acc, m, idx;
    ghist[gptr] = (s[8:0] == 9'd0) ? 10'h000 : s;
    acc = 0;
    for (int t = 0; t < 30; t++) begin
      idx = (gptr - t + 30) % 30;
      acc += sm2i(gcoef[t]) * sm2i(ghist[idx]);
    end
    gptr = (gptr + 1) % 30;
    m  = ((acc < 0) ? -acc : acc) / 512;
    so = (m > 511);
    if (m > 511) m = 511;
    y = {(acc < 0) && (m != 0), 9'(m)};
  endtask

  task automatic test_reset;
    rst4 = 1'b1; rst30 = 1'b1;
    b4.in_valid = 1'b0;  b4.out_ready = 1'b0;  b4.coef_we = 1'b0;
    b4.fir_in = '0;      b4.coef_addr = '0;    b4.coef_data = '0;
    b30.in_valid = 1'b0; b30.out_ready = 1'b0; b30.coef_we = 1'b0;
    b30.fir_in = '0;     b30.coef_addr = '0;   b30.coef_data = '0;
    tick; tick;
    tests++;
    if ({b4.out_valid, b4.in_ready, b4.sat, b4.fir_out} !== {1'b0, 1'b1, 1'b0, 10'h000}) begin
      fails++;
      $display("FAIL reset4 got ov=%b ir=%b sat=%b out=%h want ov=0 ir=1 sat=0 out=000",
               b4.out_valid, b4.in_ready, b4.sat, b4.fir_out);
    end
    tests++;
    if ({b30.out_valid, b30.in_ready, b30.sat, b30.fir_out} !== {1'b0, 1'b1, 1'b0, 10'h000}) begin
      fails++;
      $display("FAIL reset30 got ov=%b ir=%b sat=%b out=%h want ov=0 ir=1 sat=0 out=000",
               b30.out_valid, b30.in_ready, b30.sat, b30.fir_out);
    end
    rst4 = 1'b0; rst30 = 1'b0;
    tick;
  endtask

  task automatic test_impulse;
    logic [9:0] vin [4];
    logic [9:0] vexp [4];
    logic [9:0] y;
    logic so;
    int lat;
    vin  = '{10'h100, 10'h000, 10'h000, 10'h000};
    vexp = '{10'h080, 10'h240, 10'h000, 10'h020};
    wr4(0, 10'h100); wr4(1, 10'h280); wr4(2, 10'h000); wr4(3, 10'h040);
    for (int i = 0; i < 4; i++) begin
      run4(vin[i], y, so, lat);
      tests++;
      if ({so, y} !== {1'b0, vexp[i]}) begin
        fails++;
        $display("FAIL impulse[%0d] got out=%h sat=%b want out=%h sat=0", i, y, so, vexp[i]);
      end
      tests++;
      if (lat !== 4) begin
        fails++;
        $display("FAIL impulse_latency[%0d] got %0d want 4", i, lat);
      end
    end
  endtask

  task automatic test_saturation;
    logic [9:0] vin [8];
    logic [9:0] vexp [8];
    logic       sexp [8];
    logic [9:0] y;
    logic so;
    int lat;
    vin  = '{10'h1FF, 10'h1FF, 10'h1FF, 10'h1FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
    vexp = '{10'h1FE, 10'h1FF, 10'h1FF, 10'h1FF, 10'h1FF, 10'h000, 10'h3FF, 10'h3FF};
    sexp = '{1'b0,    1'b1,    1'b1,    1'b1,    1'b1,    1'b0,    1'b1,    1'b1};
    for (int i = 0; i < 4; i++) wr4(i, 10'h1FF);
    for (int i = 0; i < 8; i++) begin
      run4(vin[i], y, so, lat);
      tests++;
      if ({so, y} !== {sexp[i], vexp[i]}) begin
        fails++;
        $display("FAIL saturation[%0d] got out=%h sat=%b want out=%h sat=%b", i, y, so, vexp[i], sexp[i]);
      end
    end
  endtask

  task automatic test_neg_zero;
    logic [9:0] y;
    logic so;
    int lat;
    wr4(0, 10'h201); wr4(1, 10'h000); wr4(2, 10'h000); wr4(3, 10'h000);
    run4(10'h001, y, so, lat);
    tests++;
    if ({so, y} !== 11'h000) begin
      fails++;
      $display("FAIL neg_zero_out got out=%h sat=%b want out=000 sat=0", y, so);
    end
    run4(10'h200, y, so, lat);
    tests++;
    if ({so, y} !== 11'h000) begin
      fails++;
      $display("FAIL neg_zero_in got out=%h sat=%b want out=000 sat=0", y, so);
    end
  endtask

  task automatic test_backpressure;
    int n;
    int bad;
    wr4(0, 10'h100); wr4(1, 10'h000); wr4(2, 10'h000); wr4(3, 10'h000);
    b4.fir_in = 10'h0C8; b4.in_valid = 1'b1;
    tick;
    b4.fir_in = 10'h1FF;  // in_valid stays high through MAC and OUT
    n = 0;
    while (!b4.out_valid && n < 50) begin tick; n++; end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      b4.coef_we = i[0]; b4.coef_addr = 2'd0; b4.coef_data = 10'h1FF;
      tick;
      tests++;
      if ({b4.out_valid, b4.in_ready, b4.sat, b4.fir_out} !== {1'b1, 1'b0, 1'b0, 10'h064}) begin
        fails++; bad++;
        if (bad < 4)
          $display("FAIL backpressure_hold[%0d] got ov=%b ir=%b sat=%b out=%h want ov=1 ir=0 sat=0 out=064",
                   i, b4.out_valid, b4.in_ready, b4.sat, b4.fir_out);
      end
    end
    b4.coef_we = 1'b0;
    b4.out_ready = 1'b1;
    tick;
    b4.out_ready = 1'b0;
    tests++;
    if ({b4.out_valid, b4.in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL backpressure_release got ov=%b ir=%b want ov=0 ir=1", b4.out_valid, b4.in_ready);
    end
    tick;  // accepts 0x1FF
    b4.in_valid = 1'b0;
    n = 0;
    while (!b4.out_valid && n < 50) begin tick; n++; end
    tests++;
    if ({n, b4.sat, b4.fir_out} !== {32'd4, 1'b0, 10'h0FF}) begin
      fails++;
      $display("FAIL backpressure_next got lat=%0d out=%h sat=%b want lat=4 out=0FF sat=0",
               n, b4.fir_out, b4.sat);
    end
    b4.out_ready = 1'b1;
    tick;
    b4.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acc_c [$];
    int out_c [$];
    logic [9:0] outs [$];
    b4.fir_in = 10'h040; b4.in_valid = 1'b1; b4.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (b4.in_valid && b4.in_ready) acc_c.push_back(c);
      if (b4.out_valid && b4.out_ready) begin out_c.push_back(c); outs.push_back(b4.fir_out); end
      tick;
    end
    b4.in_valid = 1'b0;
    for (int c = 0; c < 10; c++) tick;
    b4.out_ready = 1'b0;
    tests++;
    if (acc_c.size() < 4 || out_c.size() < 3) begin
      fails++;
      $display("FAIL b2b_count got accepts=%0d outputs=%0d want >=4 and >=3", acc_c.size(), out_c.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if ({acc_c[i+1] - acc_c[i], out_c[i] - acc_c[i], 22'd0, outs[i]} !==
            {32'd6, 32'd5, 22'd0, 10'h020}) begin
          fails++;
          $display("FAIL b2b[%0d] got spacing=%0d in_to_out=%0d out=%h want spacing=6 in_to_out=5 out=020",
                   i, acc_c[i+1] - acc_c[i], out_c[i] - acc_c[i], outs[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_mac;
    logic [9:0] y;
    logic so;
    int lat;
    int seen;
    b4.fir_in = 10'h100; b4.in_valid = 1'b1;
    tick;
    b4.in_valid = 1'b0;
    tick; tick;
    rst4 = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick; if (b4.out_valid) seen++; end
    rst4 = 1'b0;
    for (int i = 0; i < 8; i++) begin tick; if (b4.out_valid) seen++; end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL reset_mid_mac_no_out got %0d out_valid cycles want 0", seen);
    end
    run4(10'h100, y, so, lat);
    tests++;
    if ({lat, so, y} !== {32'd4, 1'b0, 10'h000}) begin
      fails++;
      $display("FAIL reset_cleared_coef got lat=%0d out=%h sat=%b want lat=4 out=000 sat=0", lat, y, so);
    end
    run4(10'h000, y, so, lat);
    tests++;
    if ({so, y} !== 11'h000) begin
      fails++;
      $display("FAIL reset_cleared_hist got out=%h sat=%b want out=000 sat=0", y, so);
    end
  endtask

  task automatic test_wrap;
    logic [9:0] y, ey, s, c;
    logic so, es;
    int lat;
    int bad;
    for (int i = 0; i < 30; i++) begin gcoef[i] = '0; ghist[i] = '0; end
    gptr = 0;
    for (int i = 0; i < 30; i++) begin
      c = 10'($urandom_range(0, 1023));
      gcoef[i] = c;
      wr30(i, c);
    end
    wr30(30, 10'h1FF);  // out of range: ignored
    wr30(31, 10'h1FF);
    bad = 0;
    for (int k = 0; k < 70; k++) begin
      s = 10'($urandom_range(0, 1023));
      model30(s, ey, es);
      run30(s, 1'b0, 0, 10'h000, y, so, lat);
      tests++;
      if ({lat, so, y} !== {32'd30, es, ey}) begin
        fails++; bad++;
        if (bad < 6)
          $display("FAIL wrap[%0d] got lat=%0d out=%h sat=%b want lat=30 out=%h sat=%b",
                   k, lat, y, so, ey, es);
      end
    end
    // coefficient write in the same cycle as the accepted sample
    for (int k = 0; k < 3; k++) begin
      s = 10'($urandom_range(0, 1023));
      c = (k == 0) ? 10'h1FF : 10'($urandom_range(0, 1023));
      gcoef[0] = c;
      model30(s, ey, es);
      run30(s, 1'b1, 0, c, y, so, lat);
      tests++;
      if ({so, y} !== {es, ey}) begin
        fails++;
        $display("FAIL coef_with_sample[%0d] got out=%h sat=%b want out=%h sat=%b", k, y, so, ey, es);
      end
    end
  endtask

  initial begin
    test_reset;
    test_impulse;
    test_saturation;
    test_neg_zero;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_mac;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
